// File: rtl/e2p_pkg.sv
// Shared types and constants for the edge-to-pulse lane array.
// Used by the lane FSM and the top-level time counter.
package e2p_pkg;

   localparam int PW_MAX = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      DONE  = 2'd2
   } lane_state_t;

   // All-ones code for a TW-bit spike time ("no spike yet").
   function automatic logic [31:0] inf_time(input int tw);
      return (32'd1 << tw) - 32'd1;
   endfunction

endpackage

// File: rtl/e2p_lane.sv
// One lane: fires a PW-cycle pulse on the first edge of a gamma cycle and latches its time.
// Latency: pulse and timestamp registered on the edge that samples edge_i high; no backpressure.
// Backpressure: none; after firing the lane ignores edge_i until the next grst.
module e2p_lane
   import e2p_pkg::*;
#(
   parameter int PW = 1,
   parameter int TW = 3
) (
   input  logic          clk_i,
   input  logic          rstb_i,
   input  logic          grst_i,
   input  logic          edge_i,
   input  logic [TW-1:0] t_cnt_i,
   output logic          pulse_o,
   output logic          valid_o,
   output logic [TW-1:0] time_o
);

   localparam int            CW    = $clog2(PW_MAX + 1);
   localparam logic [CW-1:0] CLOAD = CW'(PW - 1);
   localparam logic [TW-1:0] T_INF = TW'(inf_time(TW));

   lane_state_t   state_q;
   logic [CW-1:0] cnt_q;
   logic          pulse_q;
   logic          valid_q;
   logic [TW-1:0] time_q;

   // grst outranks every state, including a pulse already in flight.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         valid_q <= 1'b0;
         time_q  <= T_INF;
      end else if (grst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         valid_q <= 1'b0;
         time_q  <= T_INF;
      end else begin
         case (state_q)
            IDLE: begin
               if (edge_i) begin
                  state_q <= PULSE;
                  cnt_q   <= CLOAD;
                  pulse_q <= 1'b1;
                  valid_q <= 1'b1;
                  time_q  <= t_cnt_i;
               end
            end
            PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  pulse_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
               pulse_q <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_o = pulse_q;
   assign valid_o = valid_q;
   assign time_o  = time_q;

endmodule

// File: rtl/edge2pulse_array.sv
// Multi-lane edge-to-pulse converter with per-lane spike timestamps since the last gamma pulse.
// Latency: pulse_out/spike_* registered on the edge that samples edge_in high; no backpressure.
// Backpressure: none; each lane fires at most once per gamma cycle.
module edge2pulse_array
   import e2p_pkg::*;
#(
   parameter int N_LANES = 8,
   parameter int PW      = 1,
   parameter int TW      = 3
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  grst,
   input  logic [N_LANES-1:0]    edge_in,
   output logic [N_LANES-1:0]    pulse_out,
   output logic [N_LANES-1:0]    spike_valid,
   output logic [N_LANES*TW-1:0] spike_time
);

   localparam logic [TW-1:0] T_INF = TW'(inf_time(TW));

   if (PW < 1 || PW > PW_MAX || TW < 1) begin : g_bad_params
      $error("edge2pulse_array: PW must be 1..PW_MAX and TW >= 1");
   end

   logic [TW-1:0] t_cnt_q;
   logic [TW-1:0] t_cnt_d;

   // Saturates rather than wraps so late edges read as the largest time.
   always_comb begin
      t_cnt_d = t_cnt_q;
      if (grst) begin
         t_cnt_d = '0;
      end else if (t_cnt_q != T_INF) begin
         t_cnt_d = t_cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         t_cnt_q <= '0;
      end else begin
         t_cnt_q <= t_cnt_d;
      end
   end

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      e2p_lane #(
         .PW (PW),
         .TW (TW)
      ) u_lane (
         .clk_i   (clk),
         .rstb_i  (rstb),
         .grst_i  (grst),
         .edge_i  (edge_in[i]),
         .t_cnt_i (t_cnt_q),
         .pulse_o (pulse_out[i]),
         .valid_o (spike_valid[i]),
         .time_o  (spike_time[i*TW +: TW])
      );
   end

endmodule
